// File: rtl/chacha20_poly1305_pkg.sv
// Shared definitions for the ChaCha20-Poly1305 MAC input feeder:
// state encodings, block widths and the byte helpers used by the datapath.
package chacha20_poly1305_pkg;

    localparam int CT_BITS   = 512;
    localparam int POLY_BITS = 128;
    localparam int LEN_BITS  = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AAD   = 3'd1,
        ST_CT    = 3'd2,
        ST_SPLIT = 3'd3,
        ST_LEN   = 3'd4,
        ST_DONE  = 3'd5
    } feeder_state_t;

    // Keep mask for the first nbytes bytes of a 16-byte block (byte 0 in the MSBs).
    // Counts above 16 saturate to a full block.
    function automatic logic [POLY_BITS-1:0] byte_mask16(input logic [4:0] nbytes);
        logic [POLY_BITS-1:0] mask;
        if (nbytes >= 5'd16) begin
            mask = '1;
        end else begin
            mask = ~({POLY_BITS{1'b1}} >> {nbytes[3:0], 3'b000});
        end
        return mask;
    endfunction

    // Reverse byte order of a 64-bit word (big-endian counter to little-endian wire order).
    function automatic logic [LEN_BITS-1:0] bswap64(input logic [LEN_BITS-1:0] x);
        logic [LEN_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = x[56-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha20_poly1305_mac_feeder_poly_block_reg.sv
// Single output register toward the Poly1305 engine. Holds a block stable
// until it is taken and allows a new load in the same cycle the old one leaves.
module poly_block_reg
    import chacha20_poly1305_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [POLY_BITS-1:0] load_data,
    input  logic                 poly_ready,
    output logic                 poly_valid,
    output logic [POLY_BITS-1:0] poly_block,
    output logic                 load_allowed
);

    assign load_allowed = !poly_valid || poly_ready;

    // Output register: clear drops any pending block, load replaces it, ready retires it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poly_valid <= 1'b0;
            poly_block <= '0;
        end else if (clear) begin
            poly_valid <= 1'b0;
            poly_block <= '0;
        end else if (load && load_allowed) begin
            poly_valid <= 1'b1;
            poly_block <= load_data;
        end else if (poly_ready) begin
            poly_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha20_poly1305_mac_feeder.sv
// Builds the Poly1305 input stream AAD || pad16 || CT || pad16 || le64(aad_len) || le64(ct_len)
// from 128-bit AAD blocks and 512-bit ciphertext blocks, one 16-byte block per load.
module chacha20_poly1305_mac_feeder
    import chacha20_poly1305_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 aad_valid,
    output logic                 aad_ready,
    input  logic [POLY_BITS-1:0] aad_data,
    input  logic [4:0]           aad_bytes,
    input  logic                 aad_last,
    input  logic                 ct_valid,
    output logic                 ct_ready,
    input  logic [CT_BITS-1:0]   ct_data,
    input  logic [6:0]           ct_bytes,
    input  logic                 ct_last,
    output logic                 poly_valid,
    input  logic                 poly_ready,
    output logic [POLY_BITS-1:0] poly_block,
    output logic                 busy,
    output logic                 mac_done
);

    feeder_state_t        state;
    feeder_state_t        state_next;
    logic [LEN_BITS-1:0]  aad_len;
    logic [LEN_BITS-1:0]  ct_len;
    logic [CT_BITS-1:0]   buf_data;
    logic [6:0]           buf_bytes;
    logic                 buf_last;
    logic                 len_loaded;

    logic                 load;
    logic [POLY_BITS-1:0] load_data;
    logic                 load_allowed;
    logic                 aad_fire;
    logic                 ct_fire;
    logic                 split_fire;
    logic                 len_load;
    logic                 len_done;

    assign busy = (state != ST_IDLE) && (state != ST_DONE);

    poly_block_reg u_out (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (start),
        .load         (load),
        .load_data    (load_data),
        .poly_ready   (poly_ready),
        .poly_valid   (poly_valid),
        .poly_block   (poly_block),
        .load_allowed (load_allowed)
    );

    // State register plus the registered mac_done pulse (length block taken by the engine).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            mac_done <= 1'b0;
        end else begin
            state    <= state_next;
            mac_done <= len_done;
        end
    end

    // Next state, handshakes and the block to load; start overrides everything.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_data  = '0;
        aad_ready  = 1'b0;
        ct_ready   = 1'b0;
        aad_fire   = 1'b0;
        ct_fire    = 1'b0;
        split_fire = 1'b0;
        len_load   = 1'b0;
        len_done   = 1'b0;
        case (state)
            ST_AAD: begin
                aad_ready = load_allowed;
                if (aad_valid && load_allowed) begin
                    aad_fire = 1'b1;
                    if (aad_bytes != 5'd0) begin
                        load      = 1'b1;
                        load_data = aad_data & byte_mask16(aad_bytes);
                    end
                    if (aad_last) begin
                        state_next = ST_CT;
                    end
                end
            end
            ST_CT: begin
                ct_ready = load_allowed;
                if (ct_valid && load_allowed) begin
                    ct_fire = 1'b1;
                    if (ct_bytes != 7'd0) begin
                        state_next = ST_SPLIT;
                    end else if (ct_last) begin
                        state_next = ST_LEN;
                    end
                end
            end
            ST_SPLIT: begin
                if (load_allowed) begin
                    load       = 1'b1;
                    split_fire = 1'b1;
                    if (buf_bytes > 7'd16) begin
                        load_data = buf_data[CT_BITS-1 -: POLY_BITS];
                    end else begin
                        load_data  = buf_data[CT_BITS-1 -: POLY_BITS] & byte_mask16(buf_bytes[4:0]);
                        state_next = buf_last ? ST_LEN : ST_CT;
                    end
                end
            end
            ST_LEN: begin
                if (!len_loaded) begin
                    if (load_allowed) begin
                        load      = 1'b1;
                        len_load  = 1'b1;
                        load_data = {bswap64(aad_len), bswap64(ct_len)};
                    end
                end else if (poly_valid && poly_ready) begin
                    len_done   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
        if (start) begin
            state_next = ST_AAD;
            load       = 1'b0;
            aad_fire   = 1'b0;
            ct_fire    = 1'b0;
            split_fire = 1'b0;
            len_load   = 1'b0;
            len_done   = 1'b0;
        end
    end

    // Length counters, ciphertext buffer and sub-block walk; start clears all of it.
    always_ff @(posedge clk) begin
        if (!reset_n || start) begin
            aad_len    <= '0;
            ct_len     <= '0;
            buf_data   <= '0;
            buf_bytes  <= '0;
            buf_last   <= 1'b0;
            len_loaded <= 1'b0;
        end else begin
            if (aad_fire) begin
                aad_len <= aad_len + LEN_BITS'(aad_bytes);
            end
            if (ct_fire) begin
                ct_len    <= ct_len + LEN_BITS'(ct_bytes);
                buf_data  <= ct_data;
                buf_bytes <= ct_bytes;
                buf_last  <= ct_last;
            end
            if (split_fire) begin
                if (buf_bytes > 7'd16) begin
                    buf_data  <= {buf_data[CT_BITS-POLY_BITS-1:0], {POLY_BITS{1'b0}}};
                    buf_bytes <= buf_bytes - 7'd16;
                end else begin
                    buf_data  <= '0;
                    buf_bytes <= '0;
                    buf_last  <= 1'b0;
                end
            end
            if (len_load) begin
                len_loaded <= 1'b1;
            end else if (len_done) begin
                len_loaded <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chacha20_poly1305_mac_feeder.sv
// Directed bench for the MAC feeder: output blocks are captured by a monitor and
// compared against hand-built expected streams in each scenario task.
module tb_chacha20_poly1305_mac_feeder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         aad_valid = 1'b0;
    logic         aad_ready;
    logic [127:0] aad_data = '0;
    logic [4:0]   aad_bytes = '0;
    logic         aad_last = 1'b0;
    logic         ct_valid = 1'b0;
    logic         ct_ready;
    logic [511:0] ct_data = '0;
    logic [6:0]   ct_bytes = '0;
    logic         ct_last = 1'b0;
    logic         poly_valid;
    logic         poly_ready = 1'b1;
    logic [127:0] poly_block;
    logic         busy;
    logic         mac_done;

    int vectors = 0;
    int errors = 0;
    logic [127:0] got_q[$];
    logic [127:0] exp_q[$];
    int cyc = 0;
    int hs_cyc = -1;
    int done_cyc = -1;
    int mac_count = 0;

    chacha20_poly1305_mac_feeder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .aad_valid  (aad_valid),
        .aad_ready  (aad_ready),
        .aad_data   (aad_data),
        .aad_bytes  (aad_bytes),
        .aad_last   (aad_last),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .ct_data    (ct_data),
        .ct_bytes   (ct_bytes),
        .ct_last    (ct_last),
        .poly_valid (poly_valid),
        .poly_ready (poly_ready),
        .poly_block (poly_block),
        .busy       (busy),
        .mac_done   (mac_done)
    );

    always #5 clk = ~clk;

    // Capture every block the engine will take at the next edge, and every mac_done pulse.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_n && !start && poly_valid && poly_ready) begin
            got_q.push_back(poly_block);
            hs_cyc = cyc;
        end
        if (mac_done) begin
            mac_count = mac_count + 1;
            done_cyc = cyc;
        end
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 29 + 7);
    endfunction

    // Expected 16-byte block: n pattern bytes starting at index first, zero padded.
    function automatic logic [127:0] exp_blk(input int first, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = (k < n) ? pat(first + k) : 8'h00;
        end
        return r;
    endfunction

    // Ciphertext input block: n pattern bytes, tail filled with 0xEE junk that must be dropped.
    function automatic logic [511:0] ct_in(input int first, input int n);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            r[511-8*k -: 8] = (k < n) ? pat(first + k) : 8'hEE;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        got_q.delete();
        exp_q.delete();
        mac_count = 0;
        hs_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic send_aad(input logic [127:0] d, input logic [4:0] n, input logic last);
        bit hs;
        int t;
        hs = 1'b0;
        t = 0;
        aad_valid = 1'b1;
        aad_data = d;
        aad_bytes = n;
        aad_last = last;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = aad_ready;
            t++;
            @(posedge clk);
            #1;
        end
        aad_valid = 1'b0;
        if (!hs) begin
            vectors++;
            errors++;
            $display("[TB] FAIL aad_accept_timeout: aad_ready=0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic send_ct(input logic [511:0] d, input logic [6:0] n, input logic last);
        bit hs;
        int t;
        hs = 1'b0;
        t = 0;
        ct_valid = 1'b1;
        ct_data = d;
        ct_bytes = n;
        ct_last = last;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = ct_ready;
            t++;
            @(posedge clk);
            #1;
        end
        ct_valid = 1'b0;
        if (!hs) begin
            vectors++;
            errors++;
            $display("[TB] FAIL ct_accept_timeout: ct_ready=0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic wait_done();
        bit seen;
        int t;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 300) begin
            @(negedge clk);
            seen = mac_done;
            t++;
        end
        @(posedge clk);
        #1;
        repeat (3) tick();
        if (!seen) begin
            vectors++;
            errors++;
            $display("[TB] FAIL mac_done_timeout: no mac_done within %0d cycles", t);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        aad_valid = 1'b1;
        ct_valid = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (poly_valid !== 1'b0 || poly_block !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_out: got valid=%b block=%h, required 0/0", poly_valid, poly_block);
        end
        vectors++;
        if (aad_ready !== 1'b0 || ct_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ready: got aad_ready=%b ct_ready=%b, required 0/0", aad_ready, ct_ready);
        end
        vectors++;
        if (busy !== 1'b0 || mac_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got busy=%b mac_done=%b, required 0/0", busy, mac_done);
        end
        @(posedge clk);
        #1;
        aad_valid = 1'b0;
        ct_valid = 1'b0;
    endtask

    task automatic test_rfc_shape();
        do_start();
        exp_q.push_back(128'h50515253c0c1c2c3c4c5c6c7_00000000);
        for (int j = 0; j < 4; j++) exp_q.push_back(exp_blk(16*j, 16));
        for (int j = 0; j < 4; j++) exp_q.push_back(exp_blk(64 + 16*j, (j < 3) ? 16 : 2));
        exp_q.push_back(128'h0c00000000000000_7200000000000000);
        send_aad(128'h50515253c0c1c2c3c4c5c6c7_deadbeef, 5'd12, 1'b1);
        send_ct(ct_in(0, 64), 7'd64, 1'b0);
        send_ct(ct_in(64, 50), 7'd50, 1'b1);
        wait_done();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL rfc_count: got %0d blocks, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL rfc_block%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (mac_count != 1) begin
            errors++;
            $display("[TB] FAIL rfc_mac_done: got %0d pulses, required 1", mac_count);
        end
    endtask

    task automatic test_empty_aad();
        do_start();
        for (int j = 0; j < 4; j++) exp_q.push_back(exp_blk(16*j, 16));
        exp_q.push_back(128'h0000000000000000_4000000000000000);
        send_aad({128{1'b1}}, 5'd0, 1'b1);
        send_ct(ct_in(0, 64), 7'd64, 1'b1);
        wait_done();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL empty_aad_count: got %0d blocks, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL empty_aad_block%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_empty_all();
        do_start();
        send_aad(128'h0, 5'd0, 1'b1);
        send_ct(512'h0, 7'd0, 1'b1);
        wait_done();
        vectors++;
        if (got_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL empty_all_count: got %0d blocks, required 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== 128'h0) begin
                errors++;
                $display("[TB] FAIL empty_all_len: got %h, required 0", got_q[0]);
            end
        end
        vectors++;
        if (mac_count != 1 || done_cyc != hs_cyc + 1) begin
            errors++;
            $display("[TB] FAIL empty_all_done: got %0d pulses at cycle %0d, required 1 at %0d",
                     mac_count, done_cyc, hs_cyc + 1);
        end
    endtask

    task automatic test_stall();
        do_start();
        for (int j = 0; j < 4; j++) exp_q.push_back(exp_blk(16*j, 16));
        exp_q.push_back(exp_blk(100, 16));
        exp_q.push_back(128'h0000000000000000_5000000000000000);
        send_aad(128'h0, 5'd0, 1'b1);
        send_ct(ct_in(0, 64), 7'd64, 1'b0);
        poly_ready = 1'b0;
        ct_valid = 1'b1;
        ct_data = ct_in(100, 16);
        ct_bytes = 7'd16;
        ct_last = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (poly_valid !== 1'b1 || poly_block !== exp_blk(0, 16) || ct_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b block=%h ct_ready=%b, required 1/%h/0",
                         k, poly_valid, poly_block, ct_ready, exp_blk(0, 16));
            end
            @(posedge clk);
            #1;
        end
        poly_ready = 1'b1;
        send_ct(ct_in(100, 16), 7'd16, 1'b1);
        wait_done();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d blocks, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL stall_block%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_abort();
        do_start();
        send_aad(128'h0, 5'd0, 1'b1);
        send_ct(ct_in(0, 64), 7'd64, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        got_q.delete();
        @(negedge clk);
        vectors++;
        if (poly_valid !== 1'b0 || aad_ready !== 1'b1 || ct_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_state: got valid=%b aad_ready=%b ct_ready=%b busy=%b, required 0/1/0/1",
                     poly_valid, aad_ready, ct_ready, busy);
        end
        @(posedge clk);
        #1;
        mac_count = 0;
        exp_q.push_back(exp_blk(200, 16));
        exp_q.push_back(exp_blk(300, 16));
        exp_q.push_back(128'h1000000000000000_1000000000000000);
        send_aad(exp_blk(200, 16), 5'd16, 1'b1);
        send_ct(ct_in(300, 16), 7'd16, 1'b1);
        wait_done();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL abort_count: got %0d blocks, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL abort_block%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (mac_count != 1) begin
            errors++;
            $display("[TB] FAIL abort_mac_done: got %0d pulses, required 1", mac_count);
        end
    endtask

    task automatic test_reset_in_len();
        do_start();
        poly_ready = 1'b0;
        send_aad(128'h0, 5'd0, 1'b1);
        send_ct(512'h0, 7'd0, 1'b1);
        tick();
        @(negedge clk);
        vectors++;
        if (poly_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len_pending: got poly_valid=%b, required 1", poly_valid);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (poly_valid !== 1'b0 || poly_block !== 128'h0 || busy !== 1'b0 ||
            aad_ready !== 1'b0 || ct_ready !== 1'b0 || mac_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len_reset: got valid=%b block=%h busy=%b aad_ready=%b ct_ready=%b done=%b, required all 0",
                     poly_valid, poly_block, busy, aad_ready, ct_ready, mac_done);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        poly_ready = 1'b1;
        repeat (5) tick();
        vectors++;
        if (mac_count != 0) begin
            errors++;
            $display("[TB] FAIL len_reset_done: got %0d mac_done pulses, required 0", mac_count);
        end
    endtask

    // Hard stop in case a scenario wedges beyond its own bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_rfc_shape();
        test_empty_aad();
        test_empty_all();
        test_stall();
        test_start_abort();
        test_reset_in_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
